dct_reod_pingpong: RTL and testbench

DCT_REOD_PINGPONG -- requirements
Module: dct_reod_pingpong

---
 rtl/dct_reod_pingpong.sv | 158 +++++++++++++++
 tb/tb_dct_reod_pingpong.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_reod_pingpong.sv
// Ping-pong frame buffer: writes each frame in DCT order (even samples up, odd samples down)
// or in natural order, and drains completed banks sequentially while the other bank fills.
module dct_reod_pingpong #(
    parameter int wData     = 16,
    parameter int LOG2_NMAX = 11,
    parameter int wPts      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sink_valid,
    output logic             sink_ready,
    input  logic [1:0]       sink_error,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic [wData-1:0] sink_real,
    input  logic [wData-1:0] sink_imag,
    input  logic [wPts-1:0]  fftpts_in,
    input  logic             reod_en,
    output logic             source_valid,
    input  logic             source_ready,
    output logic [1:0]       source_error,
    output logic             source_sop,
    output logic             source_eop,
    output logic [wData-1:0] source_real,
    output logic [wData-1:0] source_imag,
    output logic [wPts-1:0]  fftpts_out,
    output logic             frame_drop
);
    localparam int NMAX = 1 << LOG2_NMAX;
    localparam int AW   = LOG2_NMAX;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

    logic [2*wData-1:0] mem [0:2*NMAX-1];

    bank_st_t        bst    [2];
    logic [wPts-1:0] b_n    [2];
    logic [AW-1:0]   b_nm1  [2];
    logic            b_reod [2];
    logic [1:0]      b_err  [2];

    logic          wr_bank, rd_bank, out_bank;
    logic [AW-1:0] wr_idx, rd_idx;

    logic          wr_xfer, n_ok, wr_en, wr_last, cur_reod;
    logic [AW-1:0] in_nm1, cur_i, cur_nm1, wr_addr;
    logic [1:0]    new_err;
    logic [31:0]   n32;

    assign n32      = 32'(fftpts_in);
    assign n_ok     = ((fftpts_in & (fftpts_in - wPts'(1))) == '0)
                   && (n32 >= 32'd4) && (n32 <= 32'(NMAX));
    assign in_nm1   = AW'(fftpts_in - wPts'(1));

    assign sink_ready = (bst[wr_bank] == EMPTY) || (bst[wr_bank] == FILLING);
    assign wr_xfer    = sink_valid && sink_ready;

    // On sop the incoming metadata applies to this very sample, not the stored one.
    assign cur_i    = sink_sop ? '0 : wr_idx;
    assign cur_nm1  = sink_sop ? in_nm1 : b_nm1[wr_bank];
    assign cur_reod = sink_sop ? reod_en : b_reod[wr_bank];
    assign wr_last  = (cur_i == cur_nm1);
    assign wr_en    = wr_xfer && (sink_sop ? n_ok : (bst[wr_bank] == FILLING));
    assign new_err  = (sink_sop ? 2'b00 : b_err[wr_bank]) | sink_error
                    | {sink_eop != wr_last, 1'b0};

    always_comb begin
        wr_addr = cur_i;
        if (cur_reod)
            wr_addr = cur_i[0] ? (cur_nm1 - (cur_i >> 1)) : (cur_i >> 1);
    end

    logic out_adv, rd_start, rd_go, rd_last, out_done;

    assign out_adv  = !source_valid || source_ready;
    assign rd_start = (bst[rd_bank] == FULL);
    assign rd_go    = out_adv && (rd_start || (bst[rd_bank] == DRAINING));
    assign rd_last  = (rd_idx == b_nm1[rd_bank]);
    assign out_done = source_valid && source_ready && source_eop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= {sink_real, sink_imag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bst[b]    <= EMPTY;
                b_n[b]    <= '0;
                b_nm1[b]  <= '0;
                b_reod[b] <= 1'b0;
                b_err[b]  <= 2'b00;
            end
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            out_bank     <= 1'b0;
            wr_idx       <= '0;
            rd_idx       <= '0;
            frame_drop   <= 1'b0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_real  <= '0;
            source_imag  <= '0;
            source_error <= 2'b00;
            fftpts_out   <= '0;
        end else begin
            frame_drop <= 1'b0;
            if (wr_xfer && sink_sop) begin
                frame_drop      <= !n_ok || (bst[wr_bank] == FILLING);
                b_n[wr_bank]    <= fftpts_in;
                b_nm1[wr_bank]  <= in_nm1;
                b_reod[wr_bank] <= reod_en;
            end
            if (wr_en) begin
                b_err[wr_bank] <= new_err;
                if (wr_last) begin
                    bst[wr_bank] <= FULL;
                    wr_bank      <= ~wr_bank;
                    wr_idx       <= '0;
                end else begin
                    bst[wr_bank] <= FILLING;
                    wr_idx       <= cur_i + 1'b1;
                end
            end else if (wr_xfer && sink_sop) begin
                // Bad length: the frame's samples are swallowed as "no frame open".
                bst[wr_bank] <= EMPTY;
                wr_idx       <= '0;
            end

            // Bank is freed only once its last sample has left the output register.
            if (out_done) bst[out_bank] <= EMPTY;

            if (out_adv) begin
                if (rd_go) begin
                    {source_real, source_imag} <= mem[{rd_bank, rd_idx}];
                    source_valid <= 1'b1;
                    source_sop   <= (rd_idx == '0);
                    source_eop   <= rd_last;
                    source_error <= b_err[rd_bank];
                    fftpts_out   <= b_n[rd_bank];
                    out_bank     <= rd_bank;
                    if (rd_start) bst[rd_bank] <= DRAINING;
                    if (rd_last) begin
                        rd_idx  <= '0;
                        rd_bank <= ~rd_bank;
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end else begin
                    source_valid <= 1'b0;
                    source_sop   <= 1'b0;
                    source_eop   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dct_reod_pingpong.sv
// Bench for dct_reod_pingpong: directed scenarios plus random frames, checked by a
// frame-level scoreboard that builds each expected output frame from the captured input.
module tb_dct_reod_pingpong;
    logic        clk = 0, rst = 1;
    logic        sink_valid = 0, sink_sop = 0, sink_eop = 0, reod_en = 0, source_ready = 1;
    logic [1:0]  sink_error = 0;
    logic [15:0] sink_real = 0, sink_imag = 0;
    logic [11:0] fftpts_in = 0;
    logic        sink_ready, source_valid, source_sop, source_eop, frame_drop;
    logic [1:0]  source_error;
    logic [15:0] source_real, source_imag;
    logic [11:0] fftpts_out;

    dct_reod_pingpong dut (
        .clk(clk), .rst(rst),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
        .fftpts_in(fftpts_in), .reod_en(reod_en),
        .source_valid(source_valid), .source_ready(source_ready), .source_error(source_error),
        .source_sop(source_sop), .source_eop(source_eop), .source_real(source_real),
        .source_imag(source_imag), .fftpts_out(fftpts_out), .frame_drop(frame_drop)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  err;
        logic [11:0] pts;
    } smp_t;

    int   checks = 0, errors = 0, cyc = 0, rdy_mode = 0;
    smp_t exp_q[$], got_q[$];
    smp_t cur_s, held_s, mon_e;
    bit   hold_vld = 0;
    bit   m_open = 0, m_reod = 0;
    int   m_n = 0, mon_src = 0;
    logic [1:0]  m_err = 0;
    logic [31:0] m_buf[$];
    int   occ_in = 0, occ_out = 0, drops_exp = 0, drops_seen = 0, lat_in = 0, lat_out = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit valid_n(input int n);
        return (n >= 4) && (n <= 2048) && ($countones(n) == 1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       source_ready = 1'b1;
            1:       source_ready = ~source_ready;
            default: source_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor + reference model; samples between edges, where everything is stable.
    always @(negedge clk) begin
        if (!rst) begin
            cur_s.d   = {source_real, source_imag};
            cur_s.sop = source_sop;
            cur_s.eop = source_eop;
            cur_s.err = source_error;
            cur_s.pts = fftpts_out;
            if (hold_vld) chk("stall_hold", {source_valid, cur_s}, {1'b1, held_s});
            chk("sink_ready", sink_ready, (occ_in - occ_out) < 2);
            if (frame_drop) drops_seen++;
            if (source_valid && source_sop && !hold_vld) lat_out = cyc;
            hold_vld = source_valid && !source_ready;
            held_s   = cur_s;

            if (source_valid && source_ready) begin
                chk("exp_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("sample", cur_s, exp_q.pop_front());
                got_q.push_back(cur_s);
                if (source_eop) occ_out++;
            end

            if (sink_valid && sink_ready) begin
                if (sink_sop) begin
                    if (m_open || !valid_n(int'(fftpts_in))) drops_exp++;
                    m_open = valid_n(int'(fftpts_in));
                    m_n    = int'(fftpts_in);
                    m_reod = reod_en;
                    m_err  = 2'b00;
                    m_buf.delete();
                end
                if (m_open) begin
                    m_buf.push_back({sink_real, sink_imag});
                    m_err = m_err | sink_error;
                    if (sink_eop != (m_buf.size() == m_n)) m_err[1] = 1'b1;
                    if (m_buf.size() == m_n) begin
                        // DCT order: even inputs ascending, then odd inputs descending.
                        for (int k = 0; k < m_n; k++) begin
                            mon_src   = !m_reod ? k : (k < m_n / 2 ? 2 * k : 2 * (m_n - 1 - k) + 1);
                            mon_e.d   = m_buf[mon_src];
                            mon_e.sop = (k == 0);
                            mon_e.eop = (k == m_n - 1);
                            mon_e.err = m_err;
                            mon_e.pts = 12'(m_n);
                            exp_q.push_back(mon_e);
                        end
                        m_open = 0;
                        occ_in++;
                        lat_in = cyc;
                    end
                end
            end
        end
    end

    task automatic put(input bit sop, input bit eop, input logic [15:0] re, input logic [15:0] im,
                       input logic [1:0] er, input int n, input bit reod, output int waits);
        sink_valid = 1; sink_sop = sop; sink_eop = eop;
        sink_real = re; sink_imag = im; sink_error = er;
        fftpts_in = 12'(n); reod_en = reod;
        waits = 0;
        @(negedge clk);
        while (!sink_ready && waits < 4000) begin @(negedge clk); waits++; end
        chk("sink_accept", waits < 4000, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        sink_valid = 0; sink_sop = 0; sink_eop = 0;
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int n, input bit reod, input int len, input int eop_at,
                              input bit seq, input bit rerr, output int w0);
        int w;
        w0 = 0;
        for (int i = 0; i < len; i++) begin
            logic [1:0] er;
            er = (rerr && $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            put(i == 0, i == eop_at, seq ? 16'(i) : 16'($urandom), 16'($urandom), er, n, reod, w);
            if (i == 0) w0 = w;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || source_valid) && t < 5000) begin @(posedge clk); #1; t++; end
        chk("drain_done", t < 5000, 1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, d0, tot, n;
        int exp_r[8] = '{0, 2, 4, 6, 7, 5, 3, 1};

        // Reset state
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_valid", source_valid, 0);
        chk("rst_sop", source_sop, 0);
        chk("rst_eop", source_eop, 0);
        chk("rst_data", {source_real, source_imag}, 0);
        chk("rst_err", source_error, 0);
        chk("rst_pts", fftpts_out, 0);
        chk("rst_drop", frame_drop, 0);
        chk("rst_ready", sink_ready, 1);
        rst = 0;

        // N=8 DCT reorder, first transfer right after reset release
        got_q.delete();
        send_frame(8, 1, 8, 7, 1, 0, w);
        chk("first_xfer_wait", w, 0);
        idle(1);
        wait_drain();
        chk("reod8_count", got_q.size(), 8);
        chk("reod8_latency", lat_out - lat_in, 2);
        if (got_q.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("reod8_real", got_q[k].d[31:16], 16'(exp_r[k]));
            chk("reod8_sop", {got_q[0].sop, got_q[1].sop}, 2'b10);
            chk("reod8_eop", {got_q[7].eop, got_q[6].eop}, 2'b10);
            chk("reod8_pts", got_q[3].pts, 8);
            chk("reod8_err", got_q[7].err, 0);
        end

        // N=8 natural order
        got_q.delete();
        send_frame(8, 0, 8, 7, 1, 0, w);
        idle(1);
        wait_drain();
        chk("nat8_count", got_q.size(), 8);
        if (got_q.size() == 8)
            for (int k = 0; k < 8; k++) chk("nat8_real", got_q[k].d[31:16], 16'(k));

        // Three back-to-back N=16 frames with a toggling source_ready
        got_q.delete();
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) send_frame(16, f[0], 16, 15, 0, 0, w);
        idle(1);
        wait_drain();
        chk("b2b_count", got_q.size(), 48);
        rdy_mode = 0;

        // Invalid N=6, then N=4 with an early eop
        got_q.delete();
        d0 = drops_seen;
        send_frame(6, 1, 6, 5, 0, 0, w);
        idle(6);
        chk("n6_drop", drops_seen - d0, 1);
        chk("n6_no_out", got_q.size(), 0);
        send_frame(4, 1, 4, 2, 0, 0, w);
        idle(1);
        wait_drain();
        chk("n4_count", got_q.size(), 4);
        if (got_q.size() == 4) chk("n4_err1", got_q[0].err[1], 1);

        // Restart on sop at i=5 of an N=16 frame
        got_q.delete();
        d0 = drops_seen;
        send_frame(16, 1, 5, -1, 0, 0, w);
        send_frame(16, 1, 16, 15, 0, 0, w);
        idle(1);
        wait_drain();
        chk("restart_drop", drops_seen - d0, 1);
        chk("restart_count", got_q.size(), 16);

        // Random frames, random backpressure and error bits
        got_q.delete();
        rdy_mode = 2;
        tot = 0;
        for (int f = 0; f < 8; f++) begin
            n = 4 << $urandom_range(0, 4);
            send_frame(n, 1'($urandom_range(0, 1)), n, n - 1, 0, 1, w);
            tot += n;
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);
        wait_drain();
        chk("rand_count", got_q.size(), tot);
        chk("drops_total", drops_seen, drops_exp);

        // Reset in the middle of draining
        got_q.delete();
        rdy_mode = 1;
        send_frame(32, 1, 32, 31, 0, 0, w);
        idle(0);
        w = 0;
        while (got_q.size() < 5 && w < 1000) begin @(posedge clk); #1; w++; end
        chk("middrain_reached", got_q.size() >= 5, 1);
        rst = 1;
        #1;
        chk("mrst_valid", source_valid, 0);
        chk("mrst_sop_eop", {source_sop, source_eop}, 0);
        chk("mrst_data", {source_real, source_imag}, 0);
        chk("mrst_err_pts", {source_error, fftpts_out}, 0);
        chk("mrst_drop", frame_drop, 0);
        chk("mrst_ready", sink_ready, 1);
        exp_q.delete(); m_buf.delete();
        m_open = 0; occ_in = 0; occ_out = 0; hold_vld = 0;
        @(posedge clk); #1;
        rst = 0;
        rdy_mode = 0;
        got_q.delete();
        send_frame(4, 1, 4, 3, 1, 0, w);
        chk("post_rst_wait", w, 0);
        idle(1);
        wait_drain();
        chk("post_rst_count", got_q.size(), 4);
        if (got_q.size() == 4)
            chk("post_rst_real", {got_q[0].d[31:16], got_q[1].d[31:16], got_q[2].d[31:16], got_q[3].d[31:16]},
                {16'd0, 16'd2, 16'd3, 16'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
